// File: rtl/adc_capture_pkg.sv
// Shared types and default sizes for the ADC echo capture block.
package adc_capture_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int ADDR_W_DEF = 12;
  localparam int DLY_W_DEF  = 16;
  localparam int MAX_LEN    = 4096;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/adc_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port (1-cycle latency).
module adc_capture_ram
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register holds the last word between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_echo_capture.sv
// Post-burst echo capture: wait for fire, blank for delay_cfg clocks, store len_cfg samples, serve them.
// Optional macro ADC_CAPTURE_TEST_PATTERN_EN stores a wr_ptr ramp instead of adc_data.
module adc_echo_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DLY_W  = DLY_W_DEF
) (
  input  logic              clk_80mhz,
  input  logic              rst,
  input  logic              fire,
  input  logic [DLY_W-1:0]  delay_cfg,
  input  logic [ADDR_W:0]   len_cfg,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_otr,
  input  logic              rd_req,
  input  logic              ack,
  output logic              busy,
  output logic              data_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   sample_cnt,
  output logic              clip,
  output logic              trig_miss
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [DLY_W-1:0]  dly_cnt;
  logic [ADDR_W:0]   len_lat, wr_ptr, rd_ptr, len_clamped;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    len_clamped = (len_cfg > LEN_MAX) ? LEN_MAX : len_cfg;
    wr_en       = (state == CAPTURE) && (len_lat != '0);
    rd_en       = (state == DONE) && rd_req && (rd_ptr < sample_cnt);
    busy        = (state == ARMED) || (state == CAPTURE);
    data_ready  = (state == DONE);
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    wr_data     = DATA_W'(wr_ptr);
`else
    wr_data     = adc_data;
`endif
  end

  // A delay of 0 or 1 skips ARMED so the first write lands exactly delay_cfg clocks after fire
  // (the cycle after fire for 0); dly_cnt==1 means this is the last blanking cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire) state_nxt = (delay_cfg <= DLY_W'(1)) ? CAPTURE : ARMED;
      ARMED:   if (dly_cnt <= DLY_W'(1)) state_nxt = CAPTURE;
      CAPTURE: if ((len_lat == '0) || (wr_ptr == len_lat - 1'b1)) state_nxt = DONE;
      DONE:    if (ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_80mhz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk_80mhz or posedge rst) begin
    if (rst) begin
      dly_cnt    <= '0;
      len_lat    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sample_cnt <= '0;
      clip       <= 1'b0;
      trig_miss  <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      case (state)
        IDLE: if (fire) begin
          len_lat <= len_clamped;
          dly_cnt <= delay_cfg - 1'b1;
          wr_ptr  <= '0;
          clip    <= 1'b0;
        end
        ARMED: dly_cnt <= dly_cnt - 1'b1;
        CAPTURE: begin
          if (wr_en) wr_ptr <= wr_ptr + 1'b1;
          if (adc_otr) clip <= 1'b1;
          if (state_nxt == DONE) sample_cnt <= len_lat;
        end
        DONE: begin
          if (rd_en) rd_ptr <= rd_ptr + 1'b1;
          if (ack) begin
            rd_ptr    <= '0;
            trig_miss <= 1'b0;
          end
        end
        default: ;
      endcase
      // A fire that coincides with an accepted ack is still a miss, so this wins over the clear.
      if (fire && (state != IDLE)) trig_miss <= 1'b1;
    end
  end

  adc_capture_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk_80mhz),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_adc_echo_capture.sv
// Directed self-checking bench for adc_echo_capture; adc_data is a free-running ramp.
// Expected readback follows ADC_CAPTURE_TEST_PATTERN_EN when the bench is built with it.
module tb_adc_echo_capture;

  logic        clk_80mhz = 1'b0;
  logic        rst = 1'b1;
  logic        fire = 1'b0;
  logic [15:0] delay_cfg = '0;
  logic [12:0] len_cfg = '0;
  logic [11:0] adc_data = '0;
  logic        adc_otr = 1'b0;
  logic        rd_req = 1'b0;
  logic        ack = 1'b0;
  logic        busy, data_ready, rd_valid, clip, trig_miss;
  logic [11:0] rd_data;
  logic [12:0] sample_cnt;

  int checks = 0;
  int errors = 0;
  logic [11:0] base;
  int n;
  int pulses;

  adc_echo_capture dut (
    .clk_80mhz (clk_80mhz),
    .rst       (rst),
    .fire      (fire),
    .delay_cfg (delay_cfg),
    .len_cfg   (len_cfg),
    .adc_data  (adc_data),
    .adc_otr   (adc_otr),
    .rd_req    (rd_req),
    .ack       (ack),
    .busy      (busy),
    .data_ready(data_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .sample_cnt(sample_cnt),
    .clip      (clip),
    .trig_miss (trig_miss)
  );

  always #5 clk_80mhz = ~clk_80mhz;

  // Advance one clock; outputs are sampled 1 ns after the edge and the ADC ramp steps there.
  task automatic tick();
    @(posedge clk_80mhz);
    #1;
    adc_data = adc_data + 12'd1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word i of a capture whose first sample was taken from ramp value first.
  function automatic logic [11:0] exp_word(input logic [11:0] first, input int i);
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    exp_word = 12'(i);
`else
    exp_word = first + 12'(i);
`endif
  endfunction

  // Pulse fire for one cycle; base captures adc_data in the fire cycle.
  task automatic apply_stimulus(input logic [15:0] dly, input logic [12:0] len);
    delay_cfg = dly;
    len_cfg   = len;
    fire      = 1'b1;
    base      = adc_data;
    tick();
    fire      = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (!data_ready && k < budget) begin
      tick();
      k++;
    end
    check_output("ready_timeout", {31'd0, data_ready}, 32'd1);
  endtask

  task automatic read_words(input int cnt, input logic [11:0] first, input string tag);
    rd_req = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      tick();
      check_output({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
      check_output({tag, "_data"}, {20'd0, rd_data}, {20'd0, exp_word(first, i)});
    end
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check_output({tag, "_overread"}, {31'd0, rd_valid}, 32'd0);
  endtask

  task automatic send_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_output("ack_idle", {31'd0, data_ready}, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_ready", {31'd0, data_ready}, 32'd0);
    check_output("rst_valid", {31'd0, rd_valid}, 32'd0);
    check_output("rst_clip", {31'd0, clip}, 32'd0);
    check_output("rst_miss", {31'd0, trig_miss}, 32'd0);
    check_output("rst_rdata", {20'd0, rd_data}, 32'd0);
    check_output("rst_cnt", {19'd0, sample_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] basic capture delay=5 len=8");
    apply_stimulus(16'd5, 13'd8);
    check_output("basic_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 11; i++) tick();
    check_output("basic_not_ready", {31'd0, data_ready}, 32'd0);
    tick();
    check_output("basic_ready", {31'd0, data_ready}, 32'd1);
    check_output("basic_busy_low", {31'd0, busy}, 32'd0);
    check_output("basic_cnt", {19'd0, sample_cnt}, 32'd8);
    read_words(8, base + 12'd5, "basic");
    send_ack();

    $display("[TB] delay=0 len=1");
    apply_stimulus(16'd0, 13'd1);
    wait_ready(10);
    check_output("d0_cnt", {19'd0, sample_cnt}, 32'd1);
    read_words(1, base + 12'd1, "d0");
    send_ack();

    $display("[TB] flags: otr mid-capture, fire while armed");
    apply_stimulus(16'd3, 13'd10);
    fire = 1'b1;
    tick();
    fire = 1'b0;
    check_output("miss_set", {31'd0, trig_miss}, 32'd1);
    check_output("miss_busy", {31'd0, busy}, 32'd1);
    tick();
    tick();
    adc_otr = 1'b1;
    tick();
    adc_otr = 1'b0;
    check_output("clip_set", {31'd0, clip}, 32'd1);
    wait_ready(20);
    check_output("flags_cnt", {19'd0, sample_cnt}, 32'd10);
    read_words(10, base + 12'd3, "flags");
    send_ack();
    check_output("ack_clears_miss", {31'd0, trig_miss}, 32'd0);
    check_output("clip_held", {31'd0, clip}, 32'd1);

    $display("[TB] len=0, then ack with fire");
    apply_stimulus(16'd0, 13'd0);
    check_output("fire_clears_clip", {31'd0, clip}, 32'd0);
    wait_ready(10);
    check_output("len0_cnt", {19'd0, sample_cnt}, 32'd0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check_output("len0_no_valid", {31'd0, rd_valid}, 32'd0);
    ack = 1'b1;
    fire = 1'b1;
    tick();
    ack = 1'b0;
    fire = 1'b0;
    check_output("ackfire_ready", {31'd0, data_ready}, 32'd0);
    check_output("ackfire_busy", {31'd0, busy}, 32'd0);
    check_output("ackfire_miss", {31'd0, trig_miss}, 32'd1);

    $display("[TB] reset after 100 writes");
    apply_stimulus(16'd2, 13'd6);
    wait_ready(20);
    check_output("pre_rst_cnt", {19'd0, sample_cnt}, 32'd6);
    send_ack();
    apply_stimulus(16'd0, 13'd200);
    for (int i = 0; i < 100; i++) tick();
    check_output("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_output("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_output("mid_rst_cnt", {19'd0, sample_cnt}, 32'd0);
    check_output("mid_rst_miss", {31'd0, trig_miss}, 32'd0);
    tick();
    check_output("mid_rst_ready", {31'd0, data_ready}, 32'd0);
    rst = 1'b0;
    tick();
    apply_stimulus(16'd2, 13'd4);
    wait_ready(20);
    check_output("post_rst_cnt", {19'd0, sample_cnt}, 32'd4);
    read_words(4, base + 12'd2, "post_rst");
    send_ack();

    $display("[TB] clamp len_cfg=8191");
    apply_stimulus(16'd1, 13'd8191);
    wait_ready(5000);
    check_output("clamp_cnt", {19'd0, sample_cnt}, 32'd4096);
    send_ack();

    $display("[TB] full 4096 capture with 4097 reads");
    apply_stimulus(16'd0, 13'd4096);
    wait_ready(5000);
    check_output("full_cnt", {19'd0, sample_cnt}, 32'd4096);
    pulses = 0;
    rd_req = 1'b1;
    for (int i = 0; i < 4097; i++) begin
      tick();
      if (rd_valid) begin
        check_output("full_data", {20'd0, rd_data}, {20'd0, exp_word(base + 12'd1, pulses)});
        pulses++;
      end
    end
    rd_req = 1'b0;
    tick();
    check_output("full_pulses", 32'(pulses), 32'd4096);
    check_output("full_tail", {31'd0, rd_valid}, 32'd0);
    send_ack();

    n = checks;
    $display("CHECKS %0d ERRORS %0d", n, errors);
    $finish;
  end

endmodule
